// File: rtl/ex_mc.sv
// OpenMIPS execute stage: single-cycle logic/shift, iterative radix-2 multiply to HI/LO.
// Optional EX_MUL_ZERO_SKIP_EN: zero-magnitude operands bypass the BUSY iterations.
module ex_mc #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              whilo_o,
    output logic              stallreq_o
);
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam int SA_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    logic [2*DATA_W-1:0]   acc, mcand, acc_add, prod;
    logic [DATA_W-1:0]     mplier, mag1, mag2, hi_q, lo_q;
    logic [DATA_W-1:0]     logic_res, shift_res, alu_res;
    logic [CNT_W-1:0]      cnt;
    logic                  neg, is_mult, is_signed;
    logic [SA_W-1:0]       sa;

    assign is_mult   = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
    assign is_signed = (aluop_i == EXE_MULT_OP);
    assign mag1      = (is_signed && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
    assign mag2      = (is_signed && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
    assign acc_add   = acc + (mplier[0] ? mcand : '0);
    assign prod      = neg ? -acc_add : acc_add;
    assign sa        = reg1_i[SA_W-1:0];

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            default:    logic_res = '0;
        endcase
        shift_res = '0;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << sa;
            EXE_SRL_OP: shift_res = reg2_i >> sa;
            EXE_SRA_OP: shift_res = $unsigned($signed(reg2_i) >>> sa);
            default:    shift_res = '0;
        endcase
        case (alusel_i)
            EXE_RES_LOGIC: alu_res = logic_res;
            EXE_RES_SHIFT: alu_res = shift_res;
            default:       alu_res = '0;
        endcase
    end

    // Magnitudes are latched so the multiply is immune to later operand changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (flush_i) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mult) begin
`ifdef EX_MUL_ZERO_SKIP_EN
                        if (mag1 == '0 || mag2 == '0) begin
                            hi_q  <= '0;
                            lo_q  <= '0;
                            state <= DONE;
                        end else begin
`else
                        begin
`endif
                            mcand  <= {{DATA_W{1'b0}}, mag1};
                            mplier <= mag2;
                            acc    <= '0;
                            neg    <= is_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                            cnt    <= CNT_W'(DATA_W);
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc    <= acc_add;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        {hi_q, lo_q} <= prod;
                        state        <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything is forced low under reset; flush suppresses stall and strobe at once.
    always_comb begin
        wd_o       = rst ? 5'd0 : wd_i;
        wreg_o     = rst ? 1'b0 : wreg_i;
        wdata_o    = rst ? '0 : alu_res;
        whilo_o    = !rst && !flush_i && (state == DONE);
        hi_o       = whilo_o ? hi_q : '0;
        lo_o       = whilo_o ? lo_q : '0;
        stallreq_o = !rst && !flush_i &&
                     ((state == BUSY) || ((state == IDLE) && is_mult));
    end
endmodule

// File: doc/ex_mc.md
# ex_mc

Parametrised execute stage for the OpenMIPS pipeline, sitting between ID/EX and EX/MEM. Performs single-cycle logic and shift operations on DATA_W-bit operands, plus an iterative multi-cycle signed/unsigned multiply. The multiply writes a 2×DATA_W product to HI/LO and holds the pipeline through `stallreq_o` until the result is ready.

## Interface
Parameters:
- `DATA_W`, 32, operand width; power of two, ≥8. Shift amount is the low log2(DATA_W) bits of `reg1_i`.

Ports:
- Clock/reset: one clock; reset is synchronous and active-high (`clk`, `rst`).
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset (`RstEnable`)
- `flush_i`  in  1  abort any in-flight multiply
- `aluop_i`  in  `AluOpBus`  operation subtype
- `alusel_i`  in  `AluSelBus`  result class
- `reg1_i`  in  DATA_W  source operand 1
- `reg2_i`  in  DATA_W  source operand 2
- `wd_i`  in  `RegAddrBus`  destination GPR
- `wreg_i`  in  1  GPR write enable
- `wd_o`  out  `RegAddrBus`  destination GPR, passed through
- `wreg_o`  out  1  GPR write enable, passed through
- `wdata_o`  out  DATA_W  GPR result
- `hi_o`  out  DATA_W  product upper half
- `lo_o`  out  DATA_W  product lower half
- `whilo_o`  out  1  HI/LO write strobe, one cycle
- `stallreq_o`  out  1  hold upstream pipeline

## Operation
- Logic (`EXE_RES_LOGIC`): OR, AND, NOR, XOR on full DATA_W. Unlisted aluop → 0.
- Shift (`EXE_RES_SHIFT`):
  - SLL: `reg2_i << sa`.
  - SRL: logical right shift.
  - SRA: arithmetic right shift, sign-filled from `reg2_i[DATA_W-1]`.
  - sa = 0 passes `reg2_i` through unchanged.
- `wdata_o` selected by `alusel_i`; any other class → 0. `wd_o = wd_i`, `wreg_o = wreg_i`.
- Multiply (`EXE_MULT_OP` signed, `EXE_MULTU_OP` unsigned):
  - Radix-2 shift-add on magnitudes.
  - MULT: operands converted to magnitudes; product negated when the sign bits differ.
  - Full 2×DATA_W result: hi = upper half, lo = lower half. Most-negative × most-negative is exact.
- FSM:
  - IDLE: mult op present → latch magnitudes and sign, load counter = DATA_W → BUSY.
  - BUSY: each cycle, add multiplicand to accumulator if multiplier LSB = 1, shift, decrement. Counter reaches 0 → DONE.
  - DONE: drive `hi_o`/`lo_o`, pulse `whilo_o` → IDLE.
- `stallreq_o` = 1 in IDLE with a mult op present, and throughout BUSY; 0 in DONE.
- Upstream holds `aluop_i`/operands stable while `stallreq_o` = 1. The FSM ignores input changes after latching.
- `flush_i` = 1 in any state → IDLE next cycle, no `whilo_o`, `stallreq_o` = 0 that cycle.
- `rst` has priority over `flush_i`.

## Timing
- Reset: `rst` = 1 → next edge FSM = IDLE, accumulator/counter = 0. While `rst` = 1, all outputs 0: `wd_o`, `wreg_o`, `wdata_o`, `hi_o`, `lo_o`, `whilo_o`, `stallreq_o`.
- Logic/shift: combinational, 0-cycle latency, no stall.
- Multiply: op first seen in cycle 0 (IDLE).
  - BUSY in cycles 1..DATA_W; DONE in cycle DATA_W+1.
  - `stallreq_o` high cycles 0..DATA_W (DATA_W+1 cycles).
  - `whilo_o` high only in cycle DATA_W+1.
- `hi_o`/`lo_o`: registered; valid only while `whilo_o` = 1, 0 otherwise.
- Back-to-back mults: the second op in cycle DATA_W+2 (IDLE) starts a new sequence. A mult op present during DONE is not latched in that cycle.
- Reset or flush mid-BUSY: no partial result is ever strobed.

## Configuration
- `EX_MUL_ZERO_SKIP_EN`
  - Defined: in IDLE, if either operand magnitude is 0, go directly to DONE with product 0. `stallreq_o` is high 1 cycle and `whilo_o` pulses in cycle 1.
  - Undefined: zero operands take the full DATA_W+1-cycle stall.

## Test plan
- Reset: assert `rst` mid-BUSY, release → all outputs 0; a subsequent MULTU 3×5 gives hi=0, lo=15, `whilo_o` in cycle 33 (DATA_W=32).
- Shifts: SRA 0x80000000 by 4 → 0xF8000000; SRL same → 0x08000000; SLL 0x1 by 31 → 0x80000000; sa=0 → unchanged.
- Signed multiply: MULT 0xFFFFFFFF×0x00000002 → hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- Unsigned multiply: MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; `stallreq_o` high exactly 33 cycles.
- Flush: `flush_i` at BUSY cycle 10 → `stallreq_o` low next cycle, no `whilo_o` ever asserted for that op.
- Zero skip: MULT 0×0x1234 → with `EX_MUL_ZERO_SKIP_EN`, 1 stall cycle and hi=lo=0; without it, 33 stall cycles, same result.
